// File: rtl/test020_if.sv
// test020_if: host-side bus for test020.
// Carries the mem2 host port (address/we/oe/din/dout/length) and the
// test method handshake (test_req in, test_busy/test_return out).
// master: host/controller side; slave: test020 side.
interface test020_if;
    logic [31:0] mem2_address;
    logic        mem2_we;
    logic        mem2_oe;
    logic [31:0] mem2_din;
    logic [31:0] mem2_dout;
    logic [31:0] mem2_length;
    logic        test_req;
    logic        test_busy;
    logic        test_return;

    modport master (
        output mem2_address, mem2_we, mem2_oe, mem2_din, test_req,
        input  mem2_dout, mem2_length, test_busy, test_return
    );

    modport slave (
        input  mem2_address, mem2_we, mem2_oe, mem2_din, test_req,
        output mem2_dout, mem2_length, test_busy, test_return
    );
endinterface

// File: rtl/test020.sv
// test020: self-checking compute block with fields a..e, a 16-word mem2 and
// a req/busy driven `test` method (c=a+b, d=a*b, mem2[i]=i+c, e=sum(mem2)).
// Ports:
//   clk                      rising-edge clock
//   reset                    asynchronous active-low reset
//   a_in..e_in / a_we..e_we  host field writes (c..e ignored while busy)
//   a_out..e_out             field registers
//   bus (test020_if.slave)   mem2 host port and test handshake
// Optional: define TEST020_CLEAR_EN to clear test_return when a run starts.
module test020 #(
    parameter int          MEM2_DEPTH   = 16,
    parameter logic [31:0] EXPECTED_SUM = 32'd248
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic [31:0] c_in,
    input  logic [31:0] d_in,
    input  logic [31:0] e_in,
    input  logic        a_we,
    input  logic        b_we,
    input  logic        c_we,
    input  logic        d_we,
    input  logic        e_we,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [31:0] c_out,
    output logic [31:0] d_out,
    output logic [31:0] e_out,
    test020_if.slave    bus
);
    localparam int AW = $clog2(MEM2_DEPTH);
    localparam int KW = $clog2(MEM2_DEPTH + 1);
    localparam logic [KW-1:0] K_LAST = KW'(MEM2_DEPTH - 1);
    localparam logic [KW-1:0] K_END  = KW'(MEM2_DEPTH);

    typedef enum logic [2:0] {IDLE, CALC, FILL, SUM, CHECK} state_t;

    state_t      state;
    logic [31:0] mem2 [MEM2_DEPTH];
    logic [KW-1:0] k;
    logic [31:0] rd;
    logic [31:0] sum;
    logic        in_range;

    assign in_range        = bus.mem2_address < 32'(MEM2_DEPTH);
    assign bus.mem2_length = 32'(MEM2_DEPTH);

    // mem2 has no reset; the fill sequence and the idle host port share one write port
    always_ff @(posedge clk) begin
        if (state == FILL)
            mem2[k[AW-1:0]] <= 32'(k) + c_out;
        else if (!bus.test_busy && bus.mem2_we && in_range)
            mem2[bus.mem2_address[AW-1:0]] <= bus.mem2_din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            a_out           <= 32'd3;
            b_out           <= 32'd5;
            c_out           <= '0;
            d_out           <= '0;
            e_out           <= '0;
            k               <= '0;
            rd              <= '0;
            sum             <= '0;
            bus.test_busy   <= 1'b0;
            bus.test_return <= 1'b0;
            bus.mem2_dout   <= '0;
        end else begin
            if (a_we) a_out <= a_in;
            if (b_we) b_out <= b_in;
            if (!bus.test_busy) begin
                if (c_we) c_out <= c_in;
                if (d_we) d_out <= d_in;
                if (e_we) e_out <= e_in;
                if (bus.mem2_oe) bus.mem2_dout <= in_range ? mem2[bus.mem2_address[AW-1:0]] : '0;
            end
            case (state)
                IDLE: begin
                    if (bus.test_req) begin
                        state         <= CALC;
                        bus.test_busy <= 1'b1;
`ifdef TEST020_CLEAR_EN
                        bus.test_return <= 1'b0;
`endif
                    end
                end
                CALC: begin
                    c_out <= a_out + b_out;
                    d_out <= a_out * b_out;
                    k     <= '0;
                    sum   <= '0;
                    state <= FILL;
                end
                FILL: begin
                    k <= (k == K_LAST) ? '0 : k + 1'b1;
                    if (k == K_LAST) state <= SUM;
                end
                SUM: begin
                    // rd lags k by one cycle, so the final add happens at k == K_END
                    if (k != K_END) rd <= mem2[k[AW-1:0]];
                    if (k != '0) sum <= sum + rd;
                    k <= k + 1'b1;
                    if (k == K_END) state <= CHECK;
                end
                CHECK: begin
                    e_out           <= sum;
                    bus.test_return <= (sum == EXPECTED_SUM);
                    bus.test_busy   <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_test020.sv
// tb_test020: randomized self-checking bench for test020 against an arithmetic model.
module tb_test020;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] a_in = '0, b_in = '0, c_in = '0, d_in = '0, e_in = '0;
    logic        a_we = 1'b0, b_we = 1'b0, c_we = 1'b0, d_we = 1'b0, e_we = 1'b0;
    logic [31:0] a_out, b_out, c_out, d_out, e_out;
    int          n_cmp = 0;
    int          n_err = 0;

    test020_if bus();

    test020 dut (
        .clk(clk), .reset(reset),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in), .e_in(e_in),
        .a_we(a_we), .b_we(b_we), .c_we(c_we), .d_we(d_we), .e_we(e_we),
        .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out), .e_out(e_out),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // start a run with a one-cycle req pulse; lat = cycles busy stayed high after start, -1 on timeout
    task automatic run_once(output int lat);
        bus.test_req = 1'b1;
        tick;
        bus.test_req = 1'b0;
        lat = 0;
        while (bus.test_busy === 1'b1 && lat < 100) begin
            tick;
            lat++;
        end
        if (bus.test_busy !== 1'b0) lat = -1;
    endtask

    task automatic write_ab(input logic [31:0] a, input logic [31:0] b);
        a_in = a; b_in = b; a_we = 1'b1; b_we = 1'b1;
        tick;
        a_we = 1'b0; b_we = 1'b0;
    endtask

    task automatic read_mem(input logic [31:0] addr, output logic [31:0] data);
        bus.mem2_address = addr; bus.mem2_oe = 1'b1;
        tick;
        bus.mem2_oe = 1'b0;
        data = bus.mem2_dout;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (6) tick;
        n_cmp++; if (bus.test_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", bus.test_busy); end
        n_cmp++; if (bus.test_return !== 1'b0) begin n_err++; $display("FAIL reset_return got %b exp 0", bus.test_return); end
        n_cmp++; if (bus.mem2_dout !== 32'd0) begin n_err++; $display("FAIL reset_dout got %0h exp 0", bus.mem2_dout); end
        n_cmp++; if ({a_out, b_out, c_out, d_out, e_out} !== {32'd3, 32'd5, 96'd0}) begin
            n_err++; $display("FAIL reset_fields got %0h %0h %0h %0h %0h exp 3 5 0 0 0", a_out, b_out, c_out, d_out, e_out);
        end
        reset = 1'b1;
        tick;
    endtask

    task automatic test_default_run;
        int lat;
        bus.test_req = 1'b1;
        tick;
        n_cmp++; if (bus.test_busy !== 1'b1) begin n_err++; $display("FAIL busy_rise got %b exp 1", bus.test_busy); end
        bus.test_req = 1'b0;
        lat = 0;
        while (bus.test_busy === 1'b1 && lat < 100) begin tick; lat++; end
        n_cmp++; if (lat !== 35) begin n_err++; $display("FAIL default_latency got %0d exp 35", lat); end
        n_cmp++; if (bus.test_return !== 1'b1) begin n_err++; $display("FAIL default_return got %b exp 1", bus.test_return); end
        n_cmp++; if ({c_out, d_out, e_out} !== {32'd8, 32'd15, 32'd248}) begin
            n_err++; $display("FAIL default_cde got %0d %0d %0d exp 8 15 248", c_out, d_out, e_out);
        end
    endtask

    task automatic test_mem_read;
        logic [31:0] data;
        logic [31:0] addrs [3] = '{32'd0, 32'd7, 32'd15};
        foreach (addrs[i]) begin
            read_mem(addrs[i], data);
            n_cmp++; if (data !== addrs[i] + 32'd8) begin n_err++; $display("FAIL mem_read[%0d] got %0d exp %0d", addrs[i], data, addrs[i] + 32'd8); end
        end
        n_cmp++; if (bus.mem2_length !== 32'd16) begin n_err++; $display("FAIL mem2_length got %0d exp 16", bus.mem2_length); end
        bus.mem2_address = 32'd20; bus.mem2_din = 32'hBEEF; bus.mem2_we = 1'b1;
        tick;
        bus.mem2_we = 1'b0;
        read_mem(32'd20, data);
        n_cmp++; if (data !== 32'd0) begin n_err++; $display("FAIL mem_read_oor got %0h exp 0", data); end
        read_mem(32'd4, data);
        n_cmp++; if (data !== 32'd12) begin n_err++; $display("FAIL mem_alias4 got %0h exp c", data); end
    endtask

    task automatic test_field_write;
        int lat;
        write_ab(32'd4, 32'd5);
        run_once(lat);
        n_cmp++; if (lat !== 35) begin n_err++; $display("FAIL fw_latency got %0d exp 35", lat); end
        n_cmp++; if ({c_out, d_out, e_out} !== {32'd9, 32'd20, 32'd264}) begin
            n_err++; $display("FAIL fw_cde got %0d %0d %0d exp 9 20 264", c_out, d_out, e_out);
        end
        n_cmp++; if (bus.test_return !== 1'b0) begin n_err++; $display("FAIL fw_return got %b exp 0", bus.test_return); end
        write_ab(32'd3, 32'd5);
    endtask

    task automatic test_back_to_back;
        int lat;
        bus.test_req = 1'b1;
        tick;
        for (int t = 1; t < 108; t++) begin
            tick;
            n_cmp++; if (bus.test_busy !== ((t % 36) != 35)) begin
                n_err++; $display("FAIL b2b_busy t=%0d got %b exp %b", t, bus.test_busy, (t % 36) != 35);
            end
            if ((t % 36) == 35) begin
                n_cmp++; if (bus.test_return !== 1'b1) begin n_err++; $display("FAIL b2b_return t=%0d got %b exp 1", t, bus.test_return); end
            end
        end
        bus.test_req = 1'b0;
        tick;
        n_cmp++; if (bus.test_busy !== 1'b0) begin n_err++; $display("FAIL b2b_stop got %b exp 0", bus.test_busy); end
    endtask

    task automatic test_busy_ignore;
        int lat;
        logic [31:0] data;
        bus.test_req = 1'b1;
        tick;
        bus.test_req = 1'b0;
        c_in = 32'hDEAD; c_we = 1'b1;
        bus.mem2_address = 32'd3; bus.mem2_din = 32'h5555; bus.mem2_we = 1'b1;
        lat = 0;
        while (bus.test_busy === 1'b1 && lat < 30) begin tick; lat++; end
        c_we = 1'b0; bus.mem2_we = 1'b0;
        while (bus.test_busy === 1'b1 && lat < 100) begin tick; lat++; end
        n_cmp++; if (lat !== 35) begin n_err++; $display("FAIL ign_latency got %0d exp 35", lat); end
        n_cmp++; if (c_out !== 32'd8) begin n_err++; $display("FAIL ign_c got %0h exp 8", c_out); end
        n_cmp++; if (e_out !== 32'd248 || bus.test_return !== 1'b1) begin
            n_err++; $display("FAIL ign_sum got e=%0d ret=%b exp 248 1", e_out, bus.test_return);
        end
        read_mem(32'd3, data);
        n_cmp++; if (data !== 32'd11) begin n_err++; $display("FAIL ign_mem3 got %0h exp b", data); end
    endtask

    task automatic test_reset_mid_run;
        int lat;
        bus.test_req = 1'b1;
        tick;
        bus.test_req = 1'b0;
        repeat (2) tick;
        a_in = 32'd9; a_we = 1'b1;
        tick;
        a_we = 1'b0;
        n_cmp++; if (a_out !== 32'd9) begin n_err++; $display("FAIL busy_a_write got %0d exp 9", a_out); end
        repeat (6) tick;
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.test_busy !== 1'b0 || bus.test_return !== 1'b0 || a_out !== 32'd3) begin
            n_err++; $display("FAIL mid_reset got busy=%b ret=%b a=%0d exp 0 0 3", bus.test_busy, bus.test_return, a_out);
        end
        repeat (2) tick;
        reset = 1'b1;
        tick;
        run_once(lat);
        n_cmp++; if (lat !== 35 || bus.test_return !== 1'b1 || e_out !== 32'd248) begin
            n_err++; $display("FAIL rerun got lat=%0d ret=%b e=%0d exp 35 1 248", lat, bus.test_return, e_out);
        end
    endtask

    task automatic test_random;
        int lat;
        logic [31:0] a, b, c, d, s, data, addr;
        logic [31:0] model [16];
        for (int it = 0; it < 8; it++) begin
            a = $urandom;
            b = (it % 3 == 0) ? 32'd8 - a : ((it % 3 == 1) ? $urandom_range(0, 20) : $urandom);
            write_ab(a, b);
            run_once(lat);
            c = a + b;
            d = a * b;
            s = 32'd120 + 32'd16 * c;
            for (int i = 0; i < 16; i++) model[i] = c + i;
            n_cmp++; if (lat !== 35) begin n_err++; $display("FAIL rnd_latency it=%0d got %0d exp 35", it, lat); end
            n_cmp++; if ({c_out, d_out, e_out} !== {c, d, s}) begin
                n_err++; $display("FAIL rnd_cde it=%0d got %0h %0h %0h exp %0h %0h %0h", it, c_out, d_out, e_out, c, d, s);
            end
            n_cmp++; if (bus.test_return !== (s == 32'd248)) begin
                n_err++; $display("FAIL rnd_return it=%0d got %b exp %b", it, bus.test_return, s == 32'd248);
            end
            for (int j = 0; j < 4; j++) begin
                addr = $urandom_range(0, 31);
                bus.mem2_address = addr; bus.mem2_din = $urandom; bus.mem2_we = 1'b1;
                tick;
                bus.mem2_we = 1'b0;
                if (addr < 16) model[addr] = bus.mem2_din;
                addr = $urandom_range(0, 31);
                read_mem(addr, data);
                n_cmp++; if (data !== ((addr < 16) ? model[addr] : 32'd0)) begin
                    n_err++; $display("FAIL rnd_mem[%0d] got %0h exp %0h", addr, data, (addr < 16) ? model[addr] : 32'd0);
                end
            end
        end
    endtask

    initial begin
        bus.mem2_address = '0; bus.mem2_we = 1'b0; bus.mem2_oe = 1'b0; bus.mem2_din = '0; bus.test_req = 1'b0;
        test_reset;
        test_default_run;
        test_mem_read;
        test_field_write;
        test_back_to_back;
        test_busy_ignore;
        test_reset_mid_run;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
